// File: rtl/fpu_post_normalization.sv
// Post-normalization back end of the FP add/sub datapath.
// Takes the aligned mantissa sum, normalizes it one bit per cycle, rounds to
// nearest-even and packs an IEEE-754 single-precision result. Special results
// (enable=0) and exact zeros bypass the datapath straight to DONE.
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready             input handshake (in_ready high only while idle)
//   enable, special_result        normal path select / pre-computed special result
//   sign, exp, man_sum, grs       operand: sign, biased exponent, {carry,hidden,frac}, G/R/S
//   out_valid/out_ready           output handshake
//   result                        packed {sign, exponent, fraction}
//   overflow, underflow, inexact  exception flags for the delivered result
module fpu_post_normalization #(
    parameter int FORMAT_LENGTH             = 32,
    parameter int EXPONENT_LENGTH           = 8,
    parameter int FRACTION_LENGTH           = 23,
    parameter int NORMALIZE_MANTISSA_LENGTH = 24
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               enable,
    input  logic [FORMAT_LENGTH-1:0]           special_result,
    input  logic                               sign,
    input  logic [EXPONENT_LENGTH-1:0]         exp,
    input  logic [NORMALIZE_MANTISSA_LENGTH:0] man_sum,
    input  logic [2:0]                         grs,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FORMAT_LENGTH-1:0]           result,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               inexact
);
    localparam int ML = NORMALIZE_MANTISSA_LENGTH;
    localparam int EL = EXPONENT_LENGTH;
    localparam int FL = FRACTION_LENGTH;

    // Exponent carries one extra bit so overflow past the all-ones code is visible.
    localparam logic [EL:0] EXP_ONE = (EL+1)'(1);
    localparam logic [EL:0] EXP_MAX = {1'b0, {EL{1'b1}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EL:0]        exp_q, exp_d;
    logic [ML:0]        man_q, man_d;
    logic               g_q, g_d, r_q, r_d, s_q, s_d;
    logic [FORMAT_LENGTH-1:0] result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               inexact_q, inexact_d;

    logic               accept;
    logic [ML:0]        man_shl;
    logic [EL:0]        exp_dec;
    logic               round_up;
    logic [ML:0]        man_rnd, man_fin;
    logic [EL:0]        exp_fin;
    logic               rnd_inexact;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

    // Left-shift candidate: G enters at the LSB.
    assign man_shl = {man_q[ML-1:0], g_q};
    assign exp_dec = exp_q - EXP_ONE;

    // Round to nearest, ties to even, then renormalize a rounding carry.
    assign rnd_inexact = g_q | r_q | s_q;
    assign round_up    = g_q & (r_q | s_q | man_q[0]);
    assign man_rnd     = man_q + {{ML{1'b0}}, round_up};
    assign man_fin     = man_rnd[ML] ? {1'b0, man_rnd[ML:1]} : man_rnd;
    assign exp_fin     = man_rnd[ML] ? exp_q + EXP_ONE : exp_q;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        man_d       = man_q;
        g_d         = g_q;
        r_d         = r_q;
        s_d         = s_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d      = sign;
                    exp_d       = {1'b0, exp};
                    man_d       = man_sum;
                    {g_d, r_d, s_d} = grs;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b0;
                    if (!enable) begin
                        result_d = special_result;
                        state_d  = DONE;
                    end else if (man_sum == '0 && grs == 3'b000) begin
                        // Exact zero is always +0.
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (man_q[ML]) begin
                    man_d   = {1'b0, man_q[ML:1]};
                    g_d     = man_q[0];
                    r_d     = g_q;
                    s_d     = r_q | s_q;
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (!man_q[ML-1] && exp_q > EXP_ONE) begin
                    man_d = man_shl;
                    g_d   = r_q;
                    r_d   = s_q;
                    exp_d = exp_dec;
                    // Leave as soon as the shift lands normalized or hits the floor,
                    // so k shifts cost k cycles rather than k+1.
                    if (man_shl[ML-1] || exp_dec == EXP_ONE) begin
                        state_d = ROUND;
                    end
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                inexact_d = rnd_inexact;
                if (exp_fin >= EXP_MAX) begin
                    result_d   = {sign_q, {EL{1'b1}}, {FL{1'b0}}};
                    overflow_d = 1'b1;
                end else if (exp_fin == EXP_ONE && !man_fin[ML-1]) begin
                    result_d    = {sign_q, {EL{1'b0}}, man_fin[FL-1:0]};
                    underflow_d = rnd_inexact;
                end else begin
                    result_d = {sign_q, exp_fin[EL-1:0], man_fin[FL-1:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            man_q       <= man_d;
            g_q         <= g_d;
            r_q         <= r_d;
            s_q         <= s_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end
endmodule

// File: tb/tb_fpu_post_normalization.sv
module tb_fpu_post_normalization;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        enable = 1'b1;
    logic [31:0] special_result = '0;
    logic        sign = 1'b0;
    logic [7:0]  exp = '0;
    logic [24:0] man_sum = '0;
    logic [2:0]  grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, inexact;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_res;
    logic        got_ov, got_uf, got_ix;
    int          got_lat;

    always #5 clk = ~clk;

    fpu_post_normalization dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .enable         (enable),
        .special_result (special_result),
        .sign           (sign),
        .exp            (exp),
        .man_sum        (man_sum),
        .grs            (grs),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .overflow       (overflow),
        .underflow      (underflow),
        .inexact        (inexact)
    );

    // Present one operand, let it be accepted, and wait (bounded) for out_valid.
    // got_lat counts clock edges from the accept edge to out_valid high.
    task automatic issue(input logic en, input logic [31:0] sr, input logic sg,
                         input logic [7:0] e, input logic [24:0] m, input logic [2:0] gg);
        @(negedge clk);
        enable = en; special_result = sr; sign = sg; exp = e; man_sum = m; grs = gg;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got_lat = 1;
        @(negedge clk);
        while (!out_valid && got_lat < 40) begin
            @(negedge clk);
            got_lat++;
        end
        got_res = result; got_ov = overflow; got_uf = underflow; got_ix = inexact;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
        total++; if ({overflow, underflow, inexact} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {overflow, underflow, inexact});
        end
    endtask

    task automatic test_bypass();
        issue(1'b0, 32'h7FC0_0000, 1'b0, 8'h12, 25'h0AB_CDEF, 3'b111);
        total++; if (got_res !== 32'h7FC0_0000) begin bad++; $display("FAIL bypass_result got=%h want=7fc00000", got_res); end
        total++; if (got_lat !== 1) begin bad++; $display("FAIL bypass_latency got=%0d want=1", got_lat); end
        total++; if ({got_ov, got_uf, got_ix} !== 3'b000) begin
            bad++; $display("FAIL bypass_flags got=%b want=000", {got_ov, got_uf, got_ix});
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b want=0", in_ready); end
        take();
    endtask

    task automatic test_carry_backpressure();
        issue(1'b1, 32'h0, 1'b0, 8'h7F, 25'h180_0000, 3'b000);
        total++; if (got_res !== 32'h4040_0000) begin bad++; $display("FAIL carry_result got=%h want=40400000", got_res); end
        total++; if (got_lat !== 3) begin bad++; $display("FAIL carry_latency got=%0d want=3", got_lat); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || result !== 32'h4040_0000) begin
                bad++; $display("FAIL hold_%0d got valid=%b res=%h want valid=1 res=40400000", i, out_valid, result);
            end
        end
        take();
    endtask

    task automatic test_cancel();
        issue(1'b1, 32'h0, 1'b0, 8'h7E, 25'h028_0000, 3'b000);
        total++; if (got_res !== 32'h3E20_0000) begin bad++; $display("FAIL cancel_result got=%h want=3e200000", got_res); end
        total++; if (got_lat !== 4) begin bad++; $display("FAIL cancel_latency got=%0d want=4", got_lat); end
        take();
    endtask

    task automatic test_tie_even();
        issue(1'b1, 32'h0, 1'b0, 8'h7F, 25'h080_0001, 3'b100);
        total++; if (got_res !== 32'h3F80_0002 || got_ix !== 1'b1) begin
            bad++; $display("FAIL tie_odd got res=%h ix=%b want res=3f800002 ix=1", got_res, got_ix);
        end
        take();
        issue(1'b1, 32'h0, 1'b0, 8'h7F, 25'h080_0002, 3'b100);
        total++; if (got_res !== 32'h3F80_0002 || got_ix !== 1'b1) begin
            bad++; $display("FAIL tie_even got res=%h ix=%b want res=3f800002 ix=1", got_res, got_ix);
        end
        take();
        // All-ones fraction rounding up carries into bit 24: 1.111..1 + ulp = 2.0
        issue(1'b1, 32'h0, 1'b0, 8'h7F, 25'h0FF_FFFF, 3'b110);
        total++; if (got_res !== 32'h4000_0000) begin bad++; $display("FAIL round_carry got=%h want=40000000", got_res); end
        take();
    endtask

    task automatic test_overflow();
        issue(1'b1, 32'h0, 1'b1, 8'hFE, 25'h1FF_FFFE, 3'b000);
        total++; if (got_res !== 32'hFF80_0000) begin bad++; $display("FAIL ovf_result got=%h want=ff800000", got_res); end
        total++; if (got_ov !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", got_ov); end
        take();
    endtask

    task automatic test_denormal();
        issue(1'b1, 32'h0, 1'b0, 8'h01, 25'h000_0001, 3'b011);
        total++; if (got_res !== 32'h0000_0001) begin bad++; $display("FAIL denorm_result got=%h want=00000001", got_res); end
        total++; if ({got_ov, got_uf, got_ix} !== 3'b011) begin
            bad++; $display("FAIL denorm_flags got=%b want=011", {got_ov, got_uf, got_ix});
        end
        take();
    endtask

    task automatic test_zero();
        issue(1'b1, 32'hDEAD_BEEF, 1'b1, 8'h80, 25'h0, 3'b000);
        total++; if (got_res !== 32'h0) begin bad++; $display("FAIL zero_result got=%h want=00000000", got_res); end
        total++; if (got_lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", got_lat); end
        take();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'hAAAA_5555, 1'b0, 8'h0, 25'h0, 3'b000);
        // New operand presented during the cycle the result is taken must wait.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; enable = 1'b0; special_result = 32'h1234_5678;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_no_accept got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || result !== 32'h1234_5678) begin
            bad++; $display("FAIL b2b_second got valid=%b res=%h want valid=1 res=12345678", out_valid, result);
        end
        take();
    endtask

    task automatic test_reset_mid_norm();
        @(negedge clk);
        enable = 1'b1; sign = 1'b0; exp = 8'h7E; man_sum = 25'h000_0001; grs = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_idle got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        // 1.0 again after recovery
        issue(1'b1, 32'h0, 1'b0, 8'h7F, 25'h080_0000, 3'b000);
        total++; if (got_res !== 32'h3F80_0000) begin bad++; $display("FAIL rst_recover got=%h want=3f800000", got_res); end
        take();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_carry_backpressure();
        test_cancel();
        test_tie_even();
        test_overflow();
        test_denormal();
        test_zero();
        test_back_to_back();
        test_reset_mid_norm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
